mmio_key_in: RTL

Memory-mapped, debounced push-button input port on the MIPS data-memory bus; the input-side counterpart of the LED output register. Synchronises and debounces up to N_KEYS board buttons, latches press events in sticky flags, and returns them to the core on loads with the same one-cycle read latency as the data SRAM. The top level muxes `rdata` over the SRAM output whenever `rdata_valid` is high, and can optionally route `irq` to the core.

---
 rtl/mmio_key_in.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mmio_key_in.sv
// mmio_key_in: debounced memory-mapped push-button port with sticky press flags on the data bus.
// Define MMIO_KEY_IRQ_EN to implement the MASK register and drive irq; otherwise irq is tied low.
module mmio_key_in #(
  parameter int          N_KEYS          = 2,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR       = 32'd12,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic [31:0]       d_memory_address,
  input  logic              d_memory_write,
  input  logic              d_memory_read,
  input  logic [31:0]       d_memory_write_data,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              irq
);

  localparam int            CW         = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [29:0]   WORD_LEVEL = BASE_ADDR[31:2];
  localparam logic [29:0]   WORD_PRESS = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0]   WORD_MASK  = BASE_ADDR[31:2] + 30'd2;

  logic [N_KEYS-1:0] pin_pressed;
  logic [N_KEYS-1:0] sync1, sync2;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] armed;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] mask;
  logic [N_KEYS-1:0] accept, rise, w1c;
  logic [CW-1:0]     cnt [N_KEYS];
  logic [1:0]        warm;
  logic              hit_level, hit_press, hit_mask, hit_any;
  logic [31:0]       read_word;
  logic              unused_bits;

  assign pin_pressed = ACTIVE_LOW ? ~keys : keys;

  assign hit_level = (d_memory_address[31:2] == WORD_LEVEL);
  assign hit_press = (d_memory_address[31:2] == WORD_PRESS);
  assign hit_mask  = (d_memory_address[31:2] == WORD_MASK);
  assign hit_any   = hit_level | hit_press | hit_mask;

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // A key only produces press events once it has been seen released after reset,
  // so a button held through reset release does not fire a spurious press.
  assign rise = accept & sync2 & armed;
  assign w1c  = (d_memory_write && hit_press) ? d_memory_write_data[N_KEYS-1:0] : '0;

  // NOTE: every flop below uses <= so all state advances from the same pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      armed  <= '0;
      warm   <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset with the rest.
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= pin_pressed;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
        if (warm[1] && !sync2[i] && !stable[i]) armed[i] <= 1'b1;
      end
    end
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) press <= '0;
    else            press <= (press & ~w1c) | rise;
  end

`ifdef MMIO_KEY_IRQ_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (d_memory_write && hit_mask) mask <= d_memory_write_data[N_KEYS-1:0];
      irq <= |(press & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // NOTE: read_word gets a default before the decode so no path leaves it unassigned (no latch).
  always_comb begin
    read_word = '0;
    if (hit_level)      read_word[N_KEYS-1:0] = stable;
    else if (hit_press) read_word[N_KEYS-1:0] = press;
    else if (hit_mask)  read_word[N_KEYS-1:0] = mask;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= d_memory_read && hit_any;
      rdata       <= (d_memory_read && hit_any) ? read_word : '0;
    end
  end

  assign unused_bits = ^{d_memory_address[1:0], d_memory_write_data};

endmodule
